fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised, decoupled instruction-fetch stage. It keeps the PC, issues in-order requests to a
//  latency-tolerant instruction memory, buffers responses in a small fetch queue, and hands
//  {pc, inst} to decode over a valid/ready handshake. It sits between the EX redirect path and
//  decode. A redirect flushes the queue and discards in-flight responses.
// PARAMETERS
//  XLEN      64  PC/address width
//  ILEN      32  instruction width
//  RESET_PC  '0  PC loaded on reset (XLEN bits, [1:0] must be 0)
//  FQ_DEPTH  4   fetch-queue entries; also the cap on queued + outstanding requests (>=2, power of 2)
// PORTS
//  clk             in   1     clock, rising edge
//  reset           in   1     asynchronous, active-high reset
//  stall           in   1     hold: issue no new imem requests; PC frozen
//  redirect_valid  in   1     EX redirect (taken branch/jump/trap)
//  redirect_pc     in   XLEN  redirect target; bits [1:0] ignored (treated as 0)
//  imem_req_valid  out  1     request valid
//  imem_req_ready  in   1     memory accepts request
//  imem_req_addr   out  XLEN  request address (= PC)
//  imem_rsp_valid  in   1     response valid; responses return in request order, no backpressure
//  imem_rsp_inst   in   ILEN  response instruction
//  dec_valid       out  1     queue head valid
//  dec_ready       in   1     decode accepts head
//  dec_pc          out  XLEN  head PC
//  dec_inst        out  ILEN  head instruction
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=S_BOOT, queue empty, outstanding=0, drop_cnt=0; all valids 0.
//  FSM: S_BOOT -> S_RUN after one cycle (first request in the 2nd cycle after reset release).
//   S_RUN -> S_FLUSH on redirect with any in-flight request not yet returned; S_FLUSH -> S_RUN
//   when drop_cnt reaches 0. Requests may issue in S_RUN and S_FLUSH.
//  Issue: imem_req_valid = state!=S_BOOT && !stall && !redirect_valid && (fq_count+outstanding < FQ_DEPTH).
//   On req fire: pc += 4 (wraps modulo 2^XLEN), outstanding++.
//  Response: outstanding--. If drop_cnt>0 the response is discarded and drop_cnt--; else
//   {rsp_pc, inst} is written to the queue. rsp_pc comes from an internal FQ_DEPTH-deep PC-tag FIFO
//   pushed on req fire. The write is visible on dec_* the next cycle (no bypass). Credit rule makes
//   queue overflow impossible; an overflow is an assertion failure.
//  Dequeue: dec_valid = !empty; pop on dec_valid && dec_ready.
//  Redirect (highest priority, beats stall): same cycle pc<=redirect_pc; queue cleared;
//   drop_cnt <= outstanding - (imem_rsp_valid ? 1 : 0) (the response arriving that cycle is also dropped);
//   no request issued that cycle. A simultaneous dec pop is treated as completed.
//  Simultaneous req fire + rsp + pop: all counters update net of each other in one cycle.
//  stall does not block responses or dequeue. Reset mid-flight discards everything;
//   the memory system is reset together with this block.
//  Counter widths: $clog2(FQ_DEPTH+1).
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs perf_fetched (out, 32, instructions popped to decode) and
//   perf_flushed (out, 32, responses dropped + queue entries cleared by redirects). Both are
//   saturating counters, cleared by reset.
//  Not defined: ports and counters absent; no other behaviour change.
// STRUCTURE
//  fetch_pkg: fetch_state_e {S_BOOT,S_RUN,S_FLUSH}; fq_entry_t {logic [XLEN-1:0] pc; logic [ILEN-1:0] inst}
//   (parametrised via package localparams XLEN_P/ILEN_P); INST_BYTES=4.
//  Sub-module: fetch_queue (sync FIFO of fq_entry_t: push, pop, flush, count). Instantiated once for
//   the data queue and once (pc-only) as the PC-tag FIFO.
// TESTING
//  1 Reset release, 1-cycle memory, dec_ready=1 -> req addrs 0,4,8,...; first dec_valid 3 cycles after release, pc=0.
//  2 dec_ready=0, memory always ready -> exactly FQ_DEPTH(4) requests, then imem_req_valid stays 0; queue holds pc 0..0xC.
//  3 3-cycle memory latency, 3 outstanding, redirect to 0x1000 -> 3 responses dropped (2 if one arrives
//   that cycle); next dec_pc=0x1000.
//  4 redirect + stall in the same cycle -> pc=0x2000 taken; no request until stall drops; then addr 0x2000.
//  5 pc=2^XLEN-4, fetch twice -> addrs 0xFFFF_FFFF_FFFF_FFFC then 0x0.
//  6 FETCH_PERF_EN: 10 pops, one redirect dropping 2 responses + 1 queued -> perf_fetched=10, perf_flushed=3.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the decoupled instruction-fetch stage.
package fetch_pkg;
   localparam int unsigned XLEN_P     = 64;
   localparam int unsigned ILEN_P     = 32;
   localparam int unsigned INST_BYTES = 4;

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} fetch_state_e;

   typedef struct packed {
      logic [XLEN_P-1:0] pc;
      logic [ILEN_P-1:0] inst;
   } fq_entry_t;

   // Unsigned add that sticks at all-ones instead of wrapping
   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? '1 : s[31:0];
   endfunction
endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: redirect/stall control, imem request/response and decode handshake.
interface fetch_if import fetch_pkg::*; #(
   parameter int unsigned XLEN = XLEN_P,
   parameter int unsigned ILEN = ILEN_P
);
   logic            stall;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [ILEN-1:0] imem_rsp_inst;
   logic            dec_valid;
   logic            dec_ready;
   logic [XLEN-1:0] dec_pc;
   logic [ILEN-1:0] dec_inst;

   modport master (
      input  stall, redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_inst,
             dec_ready,
      output imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_inst
   );

   modport slave (
      output stall, redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_inst,
             dec_ready,
      input  imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_inst
   );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush and occupancy count; DEPTH must be a power of 2.
module fetch_queue import fetch_pkg::*; #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           push,
   input  logic [WIDTH-1:0]               wdata,
   input  logic                           pop,
   input  logic                           flush,
   output logic [WIDTH-1:0]               rdata,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           empty
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic [CW-1:0]    cnt;
   logic             full, do_push, do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];
   assign count   = cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset; occupancy is tracked by cnt
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(push && full && !pop && !flush));
endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch stage: PC, in-order imem requests, fetch queue, decode handshake.
// Optional FETCH_PERF_EN adds saturating perf_fetched / perf_flushed counters.
module fetch_unit import fetch_pkg::*; #(
   parameter int unsigned    XLEN     = XLEN_P,
   parameter int unsigned    ILEN     = ILEN_P,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned    FQ_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   fetch_if.master     bus
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_flushed
`endif
);
   localparam int unsigned CW = $clog2(FQ_DEPTH+1);

   fetch_state_e     state_q, state_d;
   logic [XLEN-1:0]  pc_q;
   logic [CW-1:0]    drop_cnt_q, drop_cnt_d;
   logic [CW-1:0]    fq_count, outstanding;
   logic             fq_empty, tag_empty;
   logic [XLEN+ILEN-1:0] fq_rdata;
   logic [XLEN-1:0]  tag_pc;
   logic             credit_ok, req_valid, req_fire, rsp, dropping, fq_push, dec_pop, redirect;

   assign redirect  = bus.redirect_valid;
   assign rsp       = bus.imem_rsp_valid;
   assign credit_ok = (({1'b0, fq_count} + {1'b0, outstanding}) < (CW+1)'(FQ_DEPTH));
   assign req_valid = (state_q != S_BOOT) && !bus.stall && !redirect && credit_ok;
   assign req_fire  = req_valid && bus.imem_req_ready;
   assign dropping  = rsp && (drop_cnt_q != '0);
   assign fq_push   = rsp && !dropping && !redirect;
   assign dec_pop   = !fq_empty && bus.dec_ready;

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = pc_q;
   assign bus.dec_valid      = !fq_empty;
   assign bus.dec_pc         = fq_rdata[XLEN+ILEN-1:ILEN];
   assign bus.dec_inst       = fq_rdata[ILEN-1:0];

   // Next state and drop counter; a response arriving with the redirect is dropped too
   always_comb begin
      state_d    = state_q;
      drop_cnt_d = drop_cnt_q;
      if (redirect)      drop_cnt_d = outstanding - CW'(rsp);
      else if (dropping) drop_cnt_d = drop_cnt_q - CW'(1);
      case (state_q)
         S_BOOT:  state_d = S_RUN;
         S_RUN:   if (redirect && drop_cnt_d != '0) state_d = S_FLUSH;
         S_FLUSH: if (drop_cnt_d == '0) state_d = S_RUN;
         default: state_d = S_BOOT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_BOOT;
         pc_q       <= RESET_PC;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         drop_cnt_q <= drop_cnt_d;
         if (redirect)      pc_q <= {bus.redirect_pc[XLEN-1:2], 2'b00};
         else if (req_fire) pc_q <= pc_q + XLEN'(INST_BYTES);
      end
   end

   fetch_queue #(.WIDTH(XLEN+ILEN), .DEPTH(FQ_DEPTH)) u_fq (
      .clk   (clk),
      .reset (reset),
      .push  (fq_push),
      .wdata ({tag_pc, bus.imem_rsp_inst}),
      .pop   (dec_pop),
      .flush (redirect),
      .rdata (fq_rdata),
      .count (fq_count),
      .empty (fq_empty)
   );

   // PC tags of in-flight requests; its occupancy is the outstanding count
   fetch_queue #(.WIDTH(XLEN), .DEPTH(FQ_DEPTH)) u_tag (
      .clk   (clk),
      .reset (reset),
      .push  (req_fire),
      .wdata (pc_q),
      .pop   (rsp),
      .flush (1'b0),
      .rdata (tag_pc),
      .count (outstanding),
      .empty (tag_empty)
   );

   a_rsp_has_tag: assert property (@(posedge clk) disable iff (reset) rsp |-> !tag_empty);

`ifdef FETCH_PERF_EN
   logic [CW:0] flush_inc;
   assign flush_inc = redirect ? ((CW+1)'(fq_count) - (CW+1)'(dec_pop) + (CW+1)'(rsp))
                               : (CW+1)'(dropping);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetched <= '0;
         perf_flushed <= '0;
      end else begin
         perf_fetched <= sat_add32(perf_fetched, 32'(dec_pop));
         perf_flushed <= sat_add32(perf_flushed, 32'(flush_inc));
      end
   end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model plus an epoch-based expected-decode model.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int unsigned FQ_DEPTH = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fetch_if #(.XLEN(64), .ILEN(32)) bus ();

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_flushed;
   int unsigned m_fetched, m_flushed;
`endif

   fetch_unit #(.XLEN(64), .ILEN(32), .RESET_PC(64'h0), .FQ_DEPTH(FQ_DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_flushed (perf_flushed)
`endif
   );

   typedef struct {
      logic [63:0] addr;
      int unsigned epoch;
      int unsigned due;
   } req_t;

   fq_entry_t   m_q[$];
   req_t        m_out[$];
   logic [63:0] m_pc;
   bit          m_boot;
   int unsigned m_epoch, cycle, lat;
   bit          s_stall, s_redirect, s_dec_ready, s_mem_ready;
   logic [63:0] s_redirect_pc;
   logic [63:0] fire_log[$], pop_log[$];
   int          first_dec_cycle;
   int          n_checks, n_fail;

   function automatic logic [31:0] inst_of(input logic [63:0] a);
      return a[33:2] ^ 32'h1357_9BDF;
   endfunction

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
      bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_inst = '0;
      bus.dec_ready = 1'b0;
      s_stall = 0; s_redirect = 0; s_redirect_pc = '0; s_dec_ready = 1; s_mem_ready = 1;
      m_q.delete(); m_out.delete(); m_pc = '0; m_boot = 1; cycle = 0;
      fire_log.delete(); pop_log.delete(); first_dec_cycle = -1;
`ifdef FETCH_PERF_EN
      m_fetched = 0; m_flushed = 0;
`endif
      #1;
      check64("reset_req_valid", 64'(bus.imem_req_valid), 64'd0);
      check64("reset_dec_valid", 64'(bus.dec_valid), 64'd0);
`ifdef FETCH_PERF_EN
      check64("reset_perf", {perf_fetched, perf_flushed}, 64'd0);
`endif
      repeat (2) @(posedge clk);
   endtask

   // One clock: drive inputs, compare outputs to the model, then advance the model
   task automatic step();
      bit   rsp, exp_req, exp_dec, fire, pop, keep;
      req_t r;
      @(negedge clk);
      reset              = 1'b0;
      bus.stall          = s_stall;
      bus.redirect_valid = s_redirect;
      bus.redirect_pc    = s_redirect_pc;
      bus.dec_ready      = s_dec_ready;
      bus.imem_req_ready = s_mem_ready;
      rsp = (m_out.size() != 0) && (m_out[0].due <= cycle);
      bus.imem_rsp_valid = rsp;
      bus.imem_rsp_inst  = rsp ? inst_of(m_out[0].addr) : 32'hDEAD_BEEF;
      #1;
      exp_req = !m_boot && !s_stall && !s_redirect && (m_q.size() + m_out.size() < FQ_DEPTH);
      exp_dec = (m_q.size() != 0);
      check64("req_valid", 64'(bus.imem_req_valid), 64'(exp_req));
      if (exp_req) check64("req_addr", bus.imem_req_addr, m_pc);
      check64("dec_valid", 64'(bus.dec_valid), 64'(exp_dec));
      if (exp_dec) begin
         check64("dec_pc", bus.dec_pc, m_q[0].pc);
         check64("dec_inst", 64'(bus.dec_inst), 64'(m_q[0].inst));
      end
`ifdef FETCH_PERF_EN
      check64("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
      check64("perf_flushed", 64'(perf_flushed), 64'(m_flushed));
`endif
      if (bus.imem_req_valid && s_mem_ready) fire_log.push_back(bus.imem_req_addr);
      if (bus.dec_valid && s_dec_ready) pop_log.push_back(bus.dec_pc);
      if (bus.dec_valid && first_dec_cycle < 0) first_dec_cycle = int'(cycle);

      fire = exp_req && s_mem_ready;
      pop  = exp_dec && s_dec_ready;
      keep = 0;
      if (rsp) begin
         r    = m_out.pop_front();
         keep = (r.epoch == m_epoch) && !s_redirect;
`ifdef FETCH_PERF_EN
         if (!keep) m_flushed++;
`endif
      end
      if (pop) begin
         void'(m_q.pop_front());
`ifdef FETCH_PERF_EN
         m_fetched++;
`endif
      end
      if (s_redirect) begin
`ifdef FETCH_PERF_EN
         m_flushed += m_q.size();
`endif
         m_q.delete();
         m_epoch++;
         m_pc = {s_redirect_pc[63:2], 2'b00};
      end else if (fire) begin
         m_out.push_back('{addr: m_pc, epoch: m_epoch, due: cycle + lat});
         m_pc += 64'd4;
      end
      if (keep) m_q.push_back('{pc: r.addr, inst: inst_of(r.addr)});
      m_boot = 0;
      cycle++;
   endtask

   initial begin
      int n;
      n_checks = 0; n_fail = 0; m_epoch = 0; lat = 1;

      // Sequential fetch, 1-cycle memory, decode always ready
      do_reset(); lat = 1;
      repeat (8) step();
      check64("t1_fires", 64'(fire_log.size() >= 3), 64'd1);
      check64("t1_addr0", fire_log[0], 64'h0);
      check64("t1_addr1", fire_log[1], 64'h4);
      check64("t1_addr2", fire_log[2], 64'h8);
      check64("t1_first_dec", 64'(first_dec_cycle), 64'd3);
      check64("t1_first_pop", pop_log[0], 64'h0);

      // Decode blocked: credit caps issue at FQ_DEPTH
      do_reset(); lat = 1; s_dec_ready = 0;
      repeat (10) step();
      check64("t2_fire_count", 64'(fire_log.size()), 64'd4);
      check64("t2_last_addr", fire_log[3], 64'hC);
      s_dec_ready = 1;
      repeat (6) step();
      check64("t2_pops", 64'(pop_log.size() >= 4), 64'd1);
      check64("t2_pop0", pop_log[0], 64'h0);
      check64("t2_pop3", pop_log[3], 64'hC);

      // 3-cycle memory, redirect with 3 in flight and one response landing that cycle
      do_reset(); lat = 3;
      repeat (4) step();
      check64("t3_pre_fires", 64'(fire_log.size()), 64'd3);
      s_redirect = 1; s_redirect_pc = 64'h1000;
      step();
      s_redirect = 0;
      repeat (12) step();
      check64("t3_fire_after", fire_log[3], 64'h1000);
      check64("t3_first_pop", pop_log[0], 64'h1000);
`ifdef FETCH_PERF_EN
      check64("t3_perf_flushed", 64'(perf_flushed), 64'd3);
`endif

      // Redirect and stall together: target taken, issue held until stall drops
      do_reset(); lat = 1;
      repeat (5) step();
      s_redirect = 1; s_stall = 1; s_redirect_pc = 64'h2000;
      step();
      s_redirect = 0;
      n = fire_log.size();
      repeat (3) step();
      check64("t4_no_fire_stalled", 64'(fire_log.size()), 64'(n));
      s_stall = 0;
      repeat (6) step();
      check64("t4_addr", fire_log[n], 64'h2000);

      // PC wrap at the top of the address space; low target bits ignored
      do_reset(); lat = 1;
      repeat (3) step();
      s_redirect = 1; s_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      s_redirect = 0;
      n = fire_log.size();
      repeat (6) step();
      check64("t5_addr_top", fire_log[n], 64'hFFFF_FFFF_FFFF_FFFC);
      check64("t5_addr_wrap", fire_log[n+1], 64'h0);

      // Mixed traffic: random ready/stall/redirect against the model
      do_reset(); lat = 2;
      for (int i = 0; i < 400; i++) begin
         s_dec_ready   = ($urandom_range(0, 3) != 0);
         s_stall       = ($urandom_range(0, 7) == 0);
         s_mem_ready   = ($urandom_range(0, 4) != 0);
         s_redirect    = ($urandom_range(0, 19) == 0);
         s_redirect_pc = {32'h0, $urandom};
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
